// File: rtl/tmds_pkg.sv
// Shared TMDS constants and types for the DVI capture-path decoder.
package tmds_pkg;

   typedef logic [1:0] ctrl_t;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   // Channel index to colour: ch0 blue, ch1 green, ch2 red.
   localparam int CH_BLUE  = 0;
   localparam int CH_GREEN = 1;
   localparam int CH_RED   = 2;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b TMDS symbol decode into control flag, control bits and data byte.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] sym,
   output logic       ctrl,
   output ctrl_t      c,
   output logic [7:0] d
);

   logic [7:0] q;

   always_comb begin
      ctrl = 1'b1;
      c    = 2'b00;
      case (sym)
         CTRL_00: c = 2'b00;
         CTRL_01: c = 2'b01;
         CTRL_10: c = 2'b10;
         CTRL_11: c = 2'b11;
         default: ctrl = 1'b0;
      endcase

      // bit9 flags inverted payload, bit8 selects XOR (1) or XNOR (0) chaining
      q    = sym[9] ? ~sym[7:0] : sym[7:0];
      d    = 8'd0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
   end

endmodule

// File: rtl/tmds_video_decoder.sv
// Three-channel TMDS to RGB decoder with sync recovery, geometry measurement,
// input-stability tracking and channel-disagreement counting.
module tmds_video_decoder
   import tmds_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
   parameter int          DIM_W          = 12
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       ch0_sym,
   input  logic [9:0]       ch1_sym,
   input  logic [9:0]       ch2_sym,
   output logic [23:0]      pix_rgb,
   output logic             pix_de,
   output logic             pix_hsync,
   output logic             pix_vsync,
   output logic [DIM_W-1:0] width,
   output logic [DIM_W-1:0] height,
   output logic             stable,
   output logic             frame_start,
   output logic [15:0]      err_cnt
);

   localparam logic [23:0] WD_LAST = TIMEOUT_CYCLES - 24'd1;

   function automatic logic [DIM_W-1:0] sat_inc_dim(input logic [DIM_W-1:0] v);
      return (&v) ? v : v + DIM_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc_err(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   logic [2:0][9:0] sym_p1;
   logic            vld_p1;
   logic [2:0]      dec_ctrl;
   logic [2:0][1:0] dec_c;
   logic [2:0][7:0] dec_d;
   logic            unused_c;

   logic [23:0]     rgb_p2;
   logic            de_p2, hsync_p2, vsync_p2, mism_p2;
   logic            de_n, mism_n;

   logic            de_p3, vsync_p3, de_fall, vs_rise;
   logic [DIM_W-1:0] hcnt, last_h, vcnt, new_w, new_h;
   logic [23:0]     wd;

   // Stage 1: register raw symbols
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sym_p1 <= '0;
      end else begin
         vld_p1          <= 1'b1;
         sym_p1[CH_BLUE]  <= ch0_sym;
         sym_p1[CH_GREEN] <= ch1_sym;
         sym_p1[CH_RED]   <= ch2_sym;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_dec
      tmds_symbol_decode u_dec (
         .sym  (sym_p1[g]),
         .ctrl (dec_ctrl[g]),
         .c    (dec_c[g]),
         .d    (dec_d[g])
      );
   end

   assign unused_c = ^{dec_c[2], dec_c[1]};
   assign de_n     = vld_p1 & ~dec_ctrl[0];
   assign mism_n   = vld_p1 & ((dec_ctrl[1] ^ dec_ctrl[0]) | (dec_ctrl[2] ^ dec_ctrl[0]));

   // Stage 2: decoded pixel, DE and sync; sync holds through active video
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_p2   <= '0;
         de_p2    <= 1'b0;
         hsync_p2 <= 1'b0;
         vsync_p2 <= 1'b0;
         mism_p2  <= 1'b0;
      end else begin
         de_p2   <= de_n;
         rgb_p2  <= de_n ? {dec_d[CH_RED], dec_d[CH_GREEN], dec_d[CH_BLUE]} : 24'd0;
         mism_p2 <= mism_n;
         if (vld_p1 && dec_ctrl[0]) begin
            hsync_p2 <= dec_c[0][0];
            vsync_p2 <= dec_c[0][1];
         end
      end
   end

   assign pix_rgb   = rgb_p2;
   assign pix_de    = de_p2;
   assign pix_hsync = hsync_p2;
   assign pix_vsync = vsync_p2;

   assign de_fall = de_p3 & ~de_p2;
   assign vs_rise = vsync_p2 & ~vsync_p3;
   // A line ending on the boundary cycle belongs to the frame being closed
   assign new_w   = de_fall ? hcnt : last_h;
   assign new_h   = de_fall ? sat_inc_dim(vcnt) : vcnt;

   // Stage 3: edge detection, geometry, stability watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         de_p3       <= 1'b0;
         vsync_p3    <= 1'b0;
         frame_start <= 1'b0;
         hcnt        <= '0;
         last_h      <= '0;
         vcnt        <= '0;
         width       <= '0;
         height      <= '0;
         stable      <= 1'b0;
         wd          <= '0;
      end else begin
         de_p3       <= de_p2;
         vsync_p3    <= vsync_p2;
         frame_start <= vs_rise;

         if (de_fall) begin
            last_h <= hcnt;
            hcnt   <= '0;
         end else if (de_p2) begin
            hcnt <= sat_inc_dim(hcnt);
         end

         if (vs_rise) begin
            width  <= new_w;
            height <= new_h;
            vcnt   <= '0;
            stable <= (new_w == width) && (new_h == height) &&
                      (new_w != '0) && (new_h != '0);
            wd     <= '0;
         end else begin
            if (de_fall) vcnt <= sat_inc_dim(vcnt);
            if (wd != TIMEOUT_CYCLES) begin
               wd <= wd + 24'd1;
               if (wd == WD_LAST) stable <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)          err_cnt <= '0;
      else if (mism_p2) err_cnt <= sat_inc_err(err_cnt);
   end

endmodule

// File: tb/tb_tmds_video_decoder.sv
// Directed bench for tmds_video_decoder: tokens, data decode, geometry, watchdog, errors, reset.
module tb_tmds_video_decoder;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] DAT = 10'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  ch0, ch1, ch2;
   logic [23:0] pix_rgb;
   logic        pix_de, pix_hsync, pix_vsync;
   logic [11:0] width, height;
   logic        stable, frame_start;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fs_count = 0;
   int fs_cyc   = 0;
   int drop_cyc = 0;
   logic stable_q = 1'b0;

   // enc_tab[value][variant]: variants are xor, xor+inv, xnor, xnor+inv
   logic [9:0] enc_tab [4][4] = '{
      '{10'h100, 10'h3FF, 10'h0AA, 10'h255},
      '{10'h155, 10'h3AA, 10'h0FF, 10'h200},
      '{10'h133, 10'h3CC, 10'h099, 10'h266},
      '{10'h19D, 10'h362, 10'h037, 10'h2C8}
   };
   logic [7:0] dval [4] = '{8'h00, 8'hFF, 8'h55, 8'hA7};
   logic [9:0] tok  [4];

   tmds_video_decoder #(
      .TIMEOUT_CYCLES (24'd1000),
      .DIM_W          (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ch0_sym     (ch0),
      .ch1_sym     (ch1),
      .ch2_sym     (ch2),
      .pix_rgb     (pix_rgb),
      .pix_de      (pix_de),
      .pix_hsync   (pix_hsync),
      .pix_vsync   (pix_vsync),
      .width       (width),
      .height      (height),
      .stable      (stable),
      .frame_start (frame_start),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_start) begin
         fs_count++;
         fs_cyc = cyc;
      end
      if (stable_q && !stable) drop_cyc = cyc;
      stable_q = stable;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      ch0 = a;
      ch1 = b;
      ch2 = c;
   endtask

   task automatic idle(input int n);
      drive(T00, T00, T00);
      repeat (n) tick();
   endtask

   task automatic vsync_pulse();
      drive(T10, T10, T10);
      repeat (3) tick();
      idle(4);
   endtask

   task automatic frame_lines(input int w, input int h);
      for (int l = 0; l < h; l++) begin
         drive(DAT, DAT, DAT);
         repeat (w) tick();
         idle(4);
      end
   endtask

   task automatic check_geom(input string tag, input int w, input int h, input int s);
      check_eq({tag, "_width"},  32'(width),  32'(w));
      check_eq({tag, "_height"}, 32'(height), 32'(h));
      check_eq({tag, "_stable"}, 32'(stable), 32'(s));
   endtask

   initial begin
      logic [23:0] exp_rgb;
      int          fs_before;
      tok[0] = T00; tok[1] = T01; tok[2] = T10; tok[3] = T11;

      rst = 1'b1;
      drive(T00, T00, T00);
      repeat (3) tick();
      check_eq("rst_de",     32'(pix_de),  0);
      check_eq("rst_rgb",    32'(pix_rgb), 0);
      check_eq("rst_width",  32'(width),   0);
      check_eq("rst_stable", 32'(stable),  0);
      check_eq("rst_err",    32'(err_cnt), 0);
      rst = 1'b0;
      idle(4);

      // control tokens, one at a time, checked at latency 2
      for (int i = 0; i < 4; i++) begin
         drive(tok[i], tok[i], tok[i]);
         tick();
         tick();
         check_eq($sformatf("tok%0d_hsync", i), 32'(pix_hsync), 32'(i % 2));
         check_eq($sformatf("tok%0d_vsync", i), 32'(pix_vsync), 32'(i / 2));
         check_eq($sformatf("tok%0d_de", i),    32'(pix_de),    0);
         check_eq($sformatf("tok%0d_rgb", i),   32'(pix_rgb),   0);
      end

      // streamed data: each output checked one tick after the next symbol is driven
      exp_rgb = '0;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) begin
            drive(enc_tab[i % 4][i / 4],
                  enc_tab[(i + 1) % 4][i / 4],
                  enc_tab[(i + 2) % 4][(i / 4 + 1) % 4]);
         end else begin
            drive(T00, T00, T00);
         end
         tick();
         if (i == 0) begin
            check_eq("lat1_de", 32'(pix_de), 0);
         end else begin
            check_eq($sformatf("dat%0d_de", i - 1),  32'(pix_de),  1);
            check_eq($sformatf("dat%0d_rgb", i - 1), 32'(pix_rgb), 32'(exp_rgb));
         end
         if (i == 1) begin
            check_eq("hold_hsync", 32'(pix_hsync), 1);
            check_eq("hold_vsync", 32'(pix_vsync), 1);
         end
         if (i < 16) exp_rgb = {dval[(i + 2) % 4], dval[(i + 1) % 4], dval[i % 4]};
      end
      idle(4);

      // geometry: three 20x30 frames then two 32x24 frames
      fs_before = fs_count;
      vsync_pulse();
      frame_lines(20, 30);
      vsync_pulse();
      check_geom("f1", 20, 30, 0);
      frame_lines(20, 30);
      vsync_pulse();
      check_geom("f2", 20, 30, 1);
      frame_lines(20, 30);
      vsync_pulse();
      check_geom("f3", 20, 30, 1);
      frame_lines(32, 24);
      vsync_pulse();
      check_geom("chg1", 32, 24, 0);
      frame_lines(32, 24);
      vsync_pulse();
      check_geom("chg2", 32, 24, 1);
      check_eq("fs_count", 32'(fs_count - fs_before), 6);

      // watchdog: no boundary for longer than the timeout
      idle(1100);
      check_eq("wd_delay",  32'(drop_cyc - fs_cyc), 1000);
      check_eq("wd_stable", 32'(stable), 0);

      frame_lines(32, 24);
      vsync_pulse();
      check_geom("resume", 32, 24, 1);

      // channel disagreement: ch1 control while ch0 carries data
      check_eq("err_before", 32'(err_cnt), 0);
      drive(DAT, T00, DAT);
      tick();
      tick();
      check_eq("dis_de", 32'(pix_de), 1);
      repeat (3) tick();
      idle(4);
      check_eq("err_after", 32'(err_cnt), 5);

      // reset in the middle of a line
      drive(DAT, DAT, DAT);
      repeat (10) tick();
      rst = 1'b1;
      repeat (2) tick();
      check_eq("mrst_rgb",   32'(pix_rgb),     0);
      check_eq("mrst_de",    32'(pix_de),      0);
      check_eq("mrst_hsync", 32'(pix_hsync),   0);
      check_eq("mrst_vsync", 32'(pix_vsync),   0);
      check_eq("mrst_width", 32'(width),       0);
      check_eq("mrst_height",32'(height),      0);
      check_eq("mrst_stable",32'(stable),      0);
      check_eq("mrst_fs",    32'(frame_start), 0);
      check_eq("mrst_err",   32'(err_cnt),     0);
      rst = 1'b0;
      tick();
      check_eq("post_rst_de", 32'(pix_de), 0);
      repeat (4) tick();
      idle(4);
      vsync_pulse();
      check_geom("post_rst", 5, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tmds_video_decoder.md
# tmds_video_decoder

Decodes the three bonded 10-bit TMDS channels from the DVI receiver into 24-bit RGB pixels with DE/HSYNC/VSYNC, and measures the incoming frame geometry. It sits directly downstream of the per-channel TMDS receivers in the capture path, in the pixel-clock domain, and feeds the capture/framebuffer writer. It also reports whether the input video is stable enough to capture.

## Interface
- `TIMEOUT_CYCLES`, default 24'd4_000_000 — pixel clocks without a frame boundary before `stable` is forced low.
- `DIM_W`, default 12 — width of the geometry counters and outputs.
- `clk`  in  1  pixel clock; the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ch0_sym`  in  10  blue channel symbol, already bonded; carries the sync control bits.
- `ch1_sym`  in  10  green channel symbol.
- `ch2_sym`  in  10  red channel symbol.
- `pix_rgb`  out  24  {R,G,B}, each 8 bits.
- `pix_de`  out  1  data enable.
- `pix_hsync`  out  1  ch0 control bit C0.
- `pix_vsync`  out  1  ch0 control bit C1.
- `width`  out  DIM_W  active pixels per line, latched at frame boundary.
- `height`  out  DIM_W  active lines per frame, latched at frame boundary.
- `stable`  out  1  geometry unchanged for two consecutive frames.
- `frame_start`  out  1  one-cycle pulse on the frame boundary.
- `err_cnt`  out  16  saturating count of channel-disagreement cycles.

## Operation
- Per-channel decode, identical for all three channels:
  - Control tokens map to {C1,C0}: 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11. The channel flags "ctrl".
  - Any other symbol is data. If bit9 is 1, bits7:0 are inverted first.
  - d0 = q0. Then di = q(i) ^ q(i−1) when bit8 = 1, or ~(q(i) ^ q(i−1)) when bit8 = 0, for i = 1..7, using the (possibly inverted) bits.
- Output assembly:
  - `pix_de` = ch0 is data.
  - When `pix_de` = 1, `pix_rgb` = decoded data.
  - When `pix_de` = 0, `pix_rgb` = 0, and hsync/vsync take ch0 C0/C1.
  - During DE, hsync/vsync hold their last control value.
- Channel disagreement: if any channel's ctrl flag differs from ch0's, `err_cnt` increments, saturating at 0xFFFF. `pix_de` still follows ch0.
- Frame boundary: the rising edge of `pix_vsync`.
- Geometry measurement:
  - `hcnt` counts DE-high cycles in the current line.
  - On DE falling edge: `last_h` ← `hcnt`, `vcnt` += 1, `hcnt` ← 0.
  - Both counters saturate at 2^DIM_W−1.
  - On a frame boundary: `width` ← `last_h`, `height` ← `vcnt`, `vcnt` ← 0, `frame_start` pulses.
  - A DE falling edge in the same cycle as the boundary is counted into the frame being closed.
- Stable tracking:
  - On each boundary, `stable` ← 1 if the new width/height equal the previously latched width/height and both are nonzero; otherwise `stable` ← 0.
  - A watchdog counts cycles since the last boundary. When it reaches TIMEOUT_CYCLES, `stable` ← 0 and the watchdog holds until the next boundary.
- Reset clears all pipeline registers, counters, `width`, `height`, `err_cnt`, `stable`, and `frame_start` to 0. Reset mid-line discards partial counts, so the first boundary after reset can never assert `stable`.

## Timing
- Pixel path latency is exactly 2 cycles: stage 1 registers the symbols, stage 2 registers the decoded outputs. Outputs for a symbol presented at cycle N appear at N+2.
- `pix_*` are all 0 from reset until the third cycle after reset deasserts.
- The edge detectors operate on the stage-2 outputs.
  - `frame_start`, `width`, and `height` update in the cycle after the `pix_vsync` 0→1 edge appears on the output.
  - `stable` updates in that same cycle.
- `err_cnt` updates one cycle after the stage-2 disagreement flag.
- No backpressure; there is one pixel per clock unconditionally.

## Structure
- Package `tmds_pkg` holds:
  - the four control-token constants;
  - the 2-bit control field type;
  - the channel-to-colour mapping constants.
- Sub-module `tmds_symbol_decode` (one per channel, three instances):
  - combinational 10b→{ctrl, c[1:0], d[7:0]};
  - the stage-2 register lives in the parent.
- The parent holds the pipeline, sync/DE assembly, geometry counters, watchdog and error counter.

## Test plan
- **Control tokens:** ch0 = 1101010100, 0010101011, 0101010100, 1010101011 in sequence → two cycles later hsync/vsync = 00, 01 (hsync = 1), 10 (vsync = 1), 11, with de = 0 and rgb = 0.
- **Data decode:** encode 0x00, 0xFF, 0x55, 0xA7 with a reference DVI encoder (both bit9 polarities) on all channels → pix_rgb equals {R,G,B} exactly at latency 2, with de = 1.
- **Geometry:** three frames of 640 active × 480 lines, vsync pulse between frames → width = 640, height = 480, frame_start pulses once per frame, stable = 0 after frame 1 and 1 after frame 2.
- **Geometry change:** switch to 800×600 → stable = 0 at the first boundary, 1 at the second.
- **Watchdog:** stop vsync with TIMEOUT_CYCLES = 1000 → stable drops exactly 1000 cycles after the last boundary.
- **Disagreement and reset:** ch1 sends a control token while ch0 sends data for 5 cycles → err_cnt = 5. Apply rst mid-line → all outputs 0 and err_cnt = 0, and stable stays 0 through the first subsequent boundary.
